// File: rtl/resp_serializer_if.sv
// resp_serializer_if: handshake bundle between the response serializer, the
// response FIFO (first-word-fall-through) and the UART TX byte sink.
//   resp_fifo_valid  FIFO non-empty
//   resp_fifo_data   head packet {opcode, addr, data, status}
//   resp_fifo_rd_en  one-cycle pop strobe
//   tx_data          byte offered to UART TX
//   tx_valid         tx_data valid
//   tx_ready         UART TX accepts the byte this cycle
// master: the serializer side.  slave: the FIFO / UART side.
interface resp_serializer_if;
    logic        resp_fifo_valid;
    logic [31:0] resp_fifo_data;
    logic        resp_fifo_rd_en;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    modport master (
        input  resp_fifo_valid, resp_fifo_data, tx_ready,
        output resp_fifo_rd_en, tx_data, tx_valid
    );

    modport slave (
        output resp_fifo_valid, resp_fifo_data, tx_ready,
        input  resp_fifo_rd_en, tx_data, tx_valid
    );
endinterface

// File: rtl/resp_serializer.sv
// resp_serializer: pops 32-bit response packets from the response FIFO and
// streams them byte-by-byte to the UART TX as a frame:
//   SYNC_BYTE, opcode, addr, data, status [, checksum]
// Optional checksum byte (opcode^addr^data^status) when RESP_CHECKSUM_EN is
// defined; otherwise frames are 5 bytes and no checksum logic exists.
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-low reset
//   bus          resp_serializer_if.master (FIFO pop side + TX byte side)
//   busy         frame in progress
//   frame_count  frames fully sent, wraps at 2^CNT_W
//   stall_err    sticky TX back-pressure timeout flag
//   clr_stall    synchronous clear of stall_err and the stall counter
module resp_serializer #(
    parameter logic [7:0] SYNC_BYTE   = 8'hA5,
    parameter int         STALL_LIMIT = 1024,
    parameter int         CNT_W       = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    resp_serializer_if.master    bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     frame_count,
    output logic                 stall_err,
    input  logic                 clr_stall
);

`ifdef RESP_CHECKSUM_EN
    localparam int FRAME_LEN = 6;
`else
    localparam int FRAME_LEN = 5;
`endif
    localparam int STALL_W = $clog2(STALL_LIMIT + 1);
    localparam logic [2:0]         LAST_IDX  = 3'(FRAME_LEN - 1);
    localparam logic [STALL_W-1:0] STALL_MAX = STALL_W'(STALL_LIMIT);

    typedef enum logic {IDLE, SEND} state_t;

    state_t             state_q, state_d;
    logic [31:0]        pkt_q, pkt_d;
    logic [2:0]         idx_q, idx_d;
    logic [CNT_W-1:0]   fc_d;
    logic [STALL_W-1:0] stall_cnt_q, stall_cnt_d;
    logic               stall_err_d;
    logic [7:0]         cur_byte;

    // Byte selected by the index; everything past the sync byte comes from
    // the latched packet so FIFO head changes cannot disturb a frame.
    always_comb begin
        cur_byte = 8'h00;
        case (idx_q)
            3'd0:    cur_byte = SYNC_BYTE;
            3'd1:    cur_byte = pkt_q[31:24];
            3'd2:    cur_byte = pkt_q[23:16];
            3'd3:    cur_byte = pkt_q[15:8];
            3'd4:    cur_byte = pkt_q[7:0];
`ifdef RESP_CHECKSUM_EN
            3'd5:    cur_byte = pkt_q[31:24] ^ pkt_q[23:16] ^ pkt_q[15:8] ^ pkt_q[7:0];
`endif
            default: cur_byte = 8'h00;
        endcase
    end

    always_comb begin
        state_d             = state_q;
        pkt_d               = pkt_q;
        idx_d               = idx_q;
        fc_d                = frame_count;
        bus.resp_fifo_rd_en = 1'b0;
        bus.tx_valid        = 1'b0;
        bus.tx_data         = 8'h00;
        case (state_q)
            IDLE: begin
                // Gated by rst so the pop strobe is low while reset is held,
                // even with a non-empty FIFO.
                if (bus.resp_fifo_valid && rst) begin
                    bus.resp_fifo_rd_en = 1'b1;
                    pkt_d               = bus.resp_fifo_data;
                    idx_d               = 3'd0;
                    state_d             = SEND;
                end
            end
            SEND: begin
                bus.tx_valid = 1'b1;
                bus.tx_data  = cur_byte;
                if (bus.tx_ready) begin
                    if (idx_q == LAST_IDX) begin
                        idx_d   = 3'd0;
                        fc_d    = frame_count + 1'b1;
                        state_d = IDLE;
                    end else begin
                        idx_d = idx_q + 3'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Stall counter saturates at STALL_MAX; stall_err latches on the cycle
    // the count reaches the limit. clr_stall overrides a same-cycle timeout.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        stall_err_d = stall_err;
        if (bus.tx_valid && bus.tx_ready) begin
            stall_cnt_d = '0;
        end else if (bus.tx_valid && (stall_cnt_q != STALL_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
            if (stall_cnt_d == STALL_MAX) stall_err_d = 1'b1;
        end
        if (clr_stall) begin
            stall_cnt_d = '0;
            stall_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            pkt_q       <= '0;
            idx_q       <= '0;
            frame_count <= '0;
            stall_cnt_q <= '0;
            stall_err   <= 1'b0;
        end else begin
            state_q     <= state_d;
            pkt_q       <= pkt_d;
            idx_q       <= idx_d;
            frame_count <= fc_d;
            stall_cnt_q <= stall_cnt_d;
            stall_err   <= stall_err_d;
        end
    end

    assign busy = (state_q == SEND);

endmodule

// File: tb/tb_resp_serializer.sv
// Directed bench for resp_serializer: FIFO and UART sink are modelled here;
// outputs are sampled on the falling edge, inputs driven 1 time unit after
// the rising edge. Expected bytes are hand-computed per packet.
module tb_resp_serializer;
    localparam int STALL_LIMIT = 1024;
    localparam int CNT_W       = 16;
`ifdef RESP_CHECKSUM_EN
    localparam int FLEN = 6;
`else
    localparam int FLEN = 5;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic clr_stall = 1'b0;
    always #5 clk = ~clk;

    resp_serializer_if bus();
    logic             busy;
    logic [CNT_W-1:0] frame_count;
    logic             stall_err;

    resp_serializer #(.SYNC_BYTE(8'hA5), .STALL_LIMIT(STALL_LIMIT), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .bus(bus), .busy(busy),
        .frame_count(frame_count), .stall_err(stall_err), .clr_stall(clr_stall)
    );

    // Narrow-counter instance: reaches the counter wrap in a few frames.
    resp_serializer_if wbus();
    logic       w_en = 1'b0;
    logic       w_busy;
    logic [3:0] w_fc;
    logic       w_err;
    assign wbus.resp_fifo_valid = w_en;
    assign wbus.resp_fifo_data  = 32'h01020304;
    assign wbus.tx_ready        = 1'b1;

    resp_serializer #(.CNT_W(4)) dut_w (
        .clk(clk), .rst(rst), .bus(wbus), .busy(w_busy),
        .frame_count(w_fc), .stall_err(w_err), .clr_stall(1'b0)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    logic [31:0] fifo[$];
    logic [7:0]  got[$];
    logic [7:0]  ex[$];
    int          xfer_cyc[$];
    int          pop_cyc[$];
    int  vld_seen, stall_seen, rmode, rphase;
    bit  pop_pend, hold_pend;
    logic [7:0] hold_byte;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        bus.resp_fifo_valid = (fifo.size() != 0);
        bus.resp_fifo_data  = (fifo.size() != 0) ? fifo[0] : 32'h0;
    endtask

    task automatic tick();
        @(negedge clk);
        if (hold_pend) begin
            chk("hold_valid", 32'(bus.tx_valid), 32'd1);
            chk("hold_data", 32'(bus.tx_data), 32'(hold_byte));
        end
        hold_pend = 1'b0;
        if (bus.resp_fifo_rd_en && !bus.resp_fifo_valid) chk("pop_empty", 32'd1, 32'd0);
        if (bus.resp_fifo_rd_en && busy) chk("pop_busy", 32'd1, 32'd0);
        if (bus.resp_fifo_rd_en) begin pop_pend = 1'b1; pop_cyc.push_back(cyc); end
        if (bus.tx_valid) vld_seen++;
        if (bus.tx_valid && bus.tx_ready) begin got.push_back(bus.tx_data); xfer_cyc.push_back(cyc); end
        if (bus.tx_valid && !bus.tx_ready) begin hold_pend = 1'b1; hold_byte = bus.tx_data; stall_seen++; end
        @(posedge clk);
        #1;
        cyc++;
        if (pop_pend) begin void'(fifo.pop_front()); pop_pend = 1'b0; end
        drive_fifo();
        case (rmode)
            0:       bus.tx_ready = 1'b1;
            1:       begin bus.tx_ready = (rphase % 3 == 0); rphase++; end
            default: bus.tx_ready = 1'b0;
        endcase
    endtask

    task automatic run_idle(input int budget);
        int n = 0;
        while (!(fifo.size() == 0 && !busy)) begin
            if (n == budget) begin chk("timeout_idle", 32'd1, 32'd0); break; end
            tick();
            n++;
        end
    endtask

    task automatic clr_logs();
        got.delete(); ex.delete(); xfer_cyc.delete(); pop_cyc.delete();
        vld_seen = 0; stall_seen = 0;
    endtask

    // Hand-computed frame for one packet; cs only emitted with the checksum.
    task automatic exp_frame(input logic [7:0] op, ad, dt, st, cs);
        ex.push_back(8'hA5); ex.push_back(op); ex.push_back(ad);
        ex.push_back(dt); ex.push_back(st);
`ifdef RESP_CHECKSUM_EN
        ex.push_back(cs);
`else
        if (cs === 8'hxx) ex.push_back(cs);
`endif
    endtask

    task automatic cmp_bytes(input string tag);
        chk({tag, "_len"}, 32'(got.size()), 32'(ex.size()));
        for (int i = 0; i < ex.size() && i < got.size(); i++)
            chk($sformatf("%s_b%0d", tag, i), 32'(got[i]), 32'(ex[i]));
    endtask

    initial begin
        int guard;
        rmode = 0; rphase = 0; vld_seen = 0; stall_seen = 0;
        pop_pend = 1'b0; hold_pend = 1'b0; hold_byte = 8'h00;
        bus.tx_ready = 1'b1;
        drive_fifo();

        // Reset state
        #3;
        chk("rst_rd_en", 32'(bus.resp_fifo_rd_en), 32'd0);
        chk("rst_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("rst_tx_data", 32'(bus.tx_data), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_fc", 32'(frame_count), 32'd0);
        chk("rst_stall", 32'(stall_err), 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Single packet, tx_ready=1
        clr_logs();
        fifo.push_back(32'h02105A00);
        drive_fifo();
        run_idle(40);
        exp_frame(8'h02, 8'h10, 8'h5A, 8'h00, 8'h48);
        cmp_bytes("s1");
        chk("s1_pops", 32'(pop_cyc.size()), 32'd1);
        chk("s1_latency", 32'(xfer_cyc[0] - pop_cyc[0]), 32'd1);
        chk("s1_contig", 32'(xfer_cyc[FLEN-1] - xfer_cyc[0]), 32'(FLEN - 1));
        chk("s1_fc", 32'(frame_count), 32'd1);

        // Two packets queued back-to-back
        clr_logs();
        fifo.push_back(32'hDEADBEEF);
        fifo.push_back(32'h11223344);
        drive_fifo();
        run_idle(60);
        exp_frame(8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h22);
        exp_frame(8'h11, 8'h22, 8'h33, 8'h44, 8'h44);
        cmp_bytes("s2");
        chk("s2_pops", 32'(pop_cyc.size()), 32'd2);
        chk("s2_gap", 32'(pop_cyc[1] - xfer_cyc[FLEN-1]), 32'd1);
        chk("s2_fc", 32'(frame_count), 32'd3);

        // tx_ready pattern 1,0,0,1,0,0...
        clr_logs();
        rmode = 1; rphase = 1;
        bus.tx_ready = 1'b1;
        fifo.push_back(32'h02105A00);
        drive_fifo();
        run_idle(80);
        rmode = 0;
        exp_frame(8'h02, 8'h10, 8'h5A, 8'h00, 8'h48);
        cmp_bytes("s3");
        chk("s3_stalled", 32'(stall_seen != 0), 32'd1);
        chk("s3_fc", 32'(frame_count), 32'd4);

        // Long stall, timeout, clear, completion
        clr_logs();
        rmode = 2;
        bus.tx_ready = 1'b0;
        fifo.push_back(32'hC3010203);
        drive_fifo();
        guard = 0;
        while (!busy && guard < 10) begin tick(); guard++; end
        chk("s4_busy", 32'(busy), 32'd1);
        guard = 0;
        while (stall_seen < STALL_LIMIT + 5 && guard < STALL_LIMIT + 50) begin
            tick();
            guard++;
            if (stall_seen == STALL_LIMIT - 1) chk("s4_err_pre", 32'(stall_err), 32'd0);
            if (stall_seen == STALL_LIMIT)     chk("s4_err_set", 32'(stall_err), 32'd1);
        end
        chk("s4_err_held", 32'(stall_err), 32'd1);
        clr_stall = 1'b1;
        tick();
        clr_stall = 1'b0;
        chk("s4_err_clr", 32'(stall_err), 32'd0);
        chk("s4_offer_valid", 32'(bus.tx_valid), 32'd1);
        chk("s4_offer_data", 32'(bus.tx_data), 32'hA5);
        rmode = 0;
        bus.tx_ready = 1'b1;
        run_idle(40);
        exp_frame(8'hC3, 8'h01, 8'h02, 8'h03, 8'hC3);
        cmp_bytes("s4");
        chk("s4_fc", 32'(frame_count), 32'd5);
        chk("s4_err_after", 32'(stall_err), 32'd0);

        // Reset while the addr byte is offered
        clr_logs();
        fifo.push_back(32'hABCDEF12);
        drive_fifo();
        guard = 0;
        while (got.size() < 2 && guard < 20) begin tick(); guard++; end
        chk("s5_addr_data", 32'(bus.tx_data), 32'hCD);
        chk("s5_addr_valid", 32'(bus.tx_valid), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("s5_tx_valid", 32'(bus.tx_valid), 32'd0);
        chk("s5_tx_data", 32'(bus.tx_data), 32'd0);
        chk("s5_busy", 32'(busy), 32'd0);
        chk("s5_fc", 32'(frame_count), 32'd0);
        chk("s5_rd_en", 32'(bus.resp_fifo_rd_en), 32'd0);
        chk("s5_stall", 32'(stall_err), 32'd0);
        repeat (2) tick();
        rst = 1'b1;
        vld_seen = 0;
        repeat (6) tick();
        chk("s5_no_valid", 32'(vld_seen), 32'd0);
        chk("s5_fc_after", 32'(frame_count), 32'd0);

        // Counter wrap (4-bit instance)
        w_en = 1'b1;
        guard = 0;
        while (w_fc != 4'hF && guard < 200) begin tick(); guard++; end
        chk("wrap_pre", 32'(w_fc), 32'hF);
        guard = 0;
        while (w_fc == 4'hF && guard < 20) begin tick(); guard++; end
        chk("wrap_zero", 32'(w_fc), 32'h0);
        w_en = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
